adc_sample_scheduler: RTL and testbench
=======================================

# adc_sample_scheduler

Consumes the one-cycle 50 Hz cycle-start strobe from the ADC timing chain and turns each 20 ms power-system cycle into SAMPLES_PER_CYCLE evenly spaced ADC conversions. Drives the ADC conversion-start pin, waits for the ADC's BUSY to clear, then hands a sample-ready strobe and the in-cycle sample index to the readout logic. Sits directly downstream of the 50 Hz pulse generator, in the same 3.2768 MHz clock domain.

## Interface
- SAMPLES_PER_CYCLE, 64: conversions per 50 Hz cycle.
- SAMPLE_PERIOD, 1024: clocks between conversion ticks (65536 / 64).
- CONVST_WIDTH, 4: clocks CONVST is held high (≥1).
- BUSY_TIMEOUT, 512: clocks allowed in WAIT_BUSY before abort.
- IDX_WIDTH, $clog2(SAMPLES_PER_CYCLE): sample index width.
- CLK  in  1  system clock, 3.2768 MHz.
- RST  in  1  reset, asynchronous, active-high.
- PULSE_50_HZ  in  1  one-cycle cycle-start strobe.
- ENABLE  in  1  level; low suppresses new ticks.
- ADC_BUSY  in  1  asynchronous ADC busy, high while converting.
- ERR_CLEAR  in  1  one-cycle clear of sticky errors.
- CONVST  out  1  ADC conversion start, registered.
- SAMPLE_VALID  out  1  one-cycle strobe: conversion complete.
- SAMPLE_IDX  out  IDX_WIDTH  index of completed sample, valid with SAMPLE_VALID.
- CYCLE_FIRST  out  1  high with SAMPLE_VALID when SAMPLE_IDX==0.
- ERR_OVERRUN  out  1  sticky: tick arrived while conversion in flight.
- ERR_TIMEOUT  out  1  sticky: BUSY did not clear within BUSY_TIMEOUT.

## Operation
- Tick generator: period counter and tick index. PULSE_50_HZ with ENABLE high: index←0, period counter←0, tick issued same cycle. Thereafter tick each time period counter reaches SAMPLE_PERIOD-1 (counter wraps to 0, index+1) until SAMPLES_PER_CYCLE ticks issued; then idle until next PULSE_50_HZ.
- PULSE_50_HZ mid-sequence: restart at index 0 (resync); remaining ticks of old cycle discarded.
- ENABLE low: no ticks issued or scheduled; in-flight conversion completes normally.
- ADC_BUSY passes through a 2-flop synchronizer before use.
- FSM states: IDLE, CONV, WAIT_BUSY, DONE.
- IDLE + tick → CONV; latch tick index.
- CONV: CONVST high; after CONVST_WIDTH cycles → WAIT_BUSY, CONVST low.
- WAIT_BUSY: synced busy low → DONE; timeout counter reaches BUSY_TIMEOUT → IDLE, ERR_TIMEOUT set, no SAMPLE_VALID.
- DONE: SAMPLE_VALID=1 one cycle with latched index → IDLE.
- Tick while FSM not IDLE: tick dropped, ERR_OVERRUN set; index still advances (indices stay time-aligned).
- Simultaneous PULSE_50_HZ and scheduled tick: PULSE wins (index 0).
- ERR_CLEAR and error event in same cycle: flag stays set.

## Timing
- Reset: CONVST, SAMPLE_VALID, CYCLE_FIRST, ERR_* = 0; SAMPLE_IDX=0; FSM IDLE; tick generator idle. Reset mid-conversion drops CONVST immediately (asynchronous).
- Tick at cycle t (IDLE): CONVST high t+1 … t+CONVST_WIDTH.
- Sample k tick at t0 + k·SAMPLE_PERIOD relative to PULSE_50_HZ at t0.
- Synchronizer adds 2 cycles: ADC_BUSY falling at cycle b → SAMPLE_VALID at b+3 (earliest).
- Timeout counter starts at WAIT_BUSY entry.

## Structure
- Package adc_timing_pkg: FSM state enum typedef, default constants (64, 1024, 4, 512), shared clock-frequency constant.
- Sub-module sync2 (2-flop synchronizer, async active-high reset to 0) for ADC_BUSY; reusable across the ADC timing chain.

## Test plan
Params 4/16/2/8 unless stated; ADC model raises BUSY 1 cycle after CONVST, lowers it 3 cycles later.
- Reset then PULSE_50_HZ at t0 → four SAMPLE_VALID, SAMPLE_IDX 0,1,2,3, spaced 16 cycles; CYCLE_FIRST only with idx 0; no errors.
- ADC model holds BUSY high 20 cycles → ERR_TIMEOUT set, no SAMPLE_VALID for that index; next tick converts normally; ERR_CLEAR clears flag.
- ADC busy 15 cycles, timeout 32 → next tick dropped, ERR_OVERRUN set, following valid reports idx 2 (skips 1).
- Second PULSE_50_HZ 24 cycles after first → idx 0,1 then restart at 0; exactly 4 further samples.
- ENABLE low before PULSE_50_HZ → no CONVST; ENABLE dropped after idx 1 tick → idx 1 completes, no idx 2/3.
- RST asserted while CONVST high → CONVST low same cycle, all outputs 0; next PULSE restarts at idx 0.

Source files
------------

// File: rtl/adc_timing_pkg.sv
// Shared types and default constants for the ADC timing chain.
package adc_timing_pkg;

   localparam int unsigned ClkFreqHz          = 3_276_800;
   localparam int unsigned DefSamplesPerCycle = 64;
   localparam int unsigned DefSamplePeriod    = 1024;
   localparam int unsigned DefConvstWidth     = 4;
   localparam int unsigned DefBusyTimeout     = 512;

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StWaitBusy,
      StDone
   } sched_state_e;

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// Control, ADC handshake and readout signals of the sample scheduler.
interface adc_sample_scheduler_if
   import adc_timing_pkg::*;
#(
   parameter int unsigned IDX_WIDTH = $clog2(DefSamplesPerCycle)
);

   logic                 PULSE_50_HZ;
   logic                 ENABLE;
   logic                 ADC_BUSY;
   logic                 ERR_CLEAR;
   logic                 CONVST;
   logic                 SAMPLE_VALID;
   logic [IDX_WIDTH-1:0] SAMPLE_IDX;
   logic                 CYCLE_FIRST;
   logic                 ERR_OVERRUN;
   logic                 ERR_TIMEOUT;

   modport master (
      output PULSE_50_HZ, ENABLE, ADC_BUSY, ERR_CLEAR,
      input  CONVST, SAMPLE_VALID, SAMPLE_IDX, CYCLE_FIRST, ERR_OVERRUN, ERR_TIMEOUT
   );

   modport slave (
      input  PULSE_50_HZ, ENABLE, ADC_BUSY, ERR_CLEAR,
      output CONVST, SAMPLE_VALID, SAMPLE_IDX, CYCLE_FIRST, ERR_OVERRUN, ERR_TIMEOUT
   );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync2 (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic Q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= D;
         sync_q <= meta_q;
      end
   end

   assign Q = sync_q;

endmodule

// File: rtl/adc_sample_scheduler.sv
// Splits each 50 Hz cycle into evenly spaced ADC conversions and reports every
// completed sample with its in-cycle index.
module adc_sample_scheduler
   import adc_timing_pkg::*;
#(
   parameter int unsigned SAMPLES_PER_CYCLE = DefSamplesPerCycle,
   parameter int unsigned SAMPLE_PERIOD     = DefSamplePeriod,
   parameter int unsigned CONVST_WIDTH      = DefConvstWidth,
   parameter int unsigned BUSY_TIMEOUT      = DefBusyTimeout,
   parameter int unsigned IDX_WIDTH         = $clog2(SAMPLES_PER_CYCLE)
) (
   input  logic                  CLK,
   input  logic                  RST,
   adc_sample_scheduler_if.slave bus
);

   localparam int unsigned PCntW     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned FsmCntMax = (CONVST_WIDTH > BUSY_TIMEOUT) ? CONVST_WIDTH : BUSY_TIMEOUT;
   localparam int unsigned FsmCntW   = $clog2(FsmCntMax + 1);

   logic                 busy_sync;

   logic                 gen_active_q, gen_active_d;
   logic [PCntW-1:0]     period_cnt_q, period_cnt_d;
   logic [IDX_WIDTH-1:0] tick_idx_q, tick_idx_d;
   logic                 tick;

   sched_state_e         state_q, state_d;
   logic [FsmCntW-1:0]   cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0] lat_idx_q, lat_idx_d;

   logic                 convst_q, convst_d;
   logic                 valid_q, valid_d;
   logic                 first_q, first_d;
   logic [IDX_WIDTH-1:0] sample_idx_q, sample_idx_d;
   logic                 err_overrun_q, err_overrun_d;
   logic                 err_timeout_q, err_timeout_d;
   logic                 overrun_evt;
   logic                 timeout_evt;

   sync2 u_busy_sync (
      .CLK (CLK),
      .RST (RST),
      .D   (bus.ADC_BUSY),
      .Q   (busy_sync)
   );

   // Tick generator: a pulse always restarts the sequence at index 0, even mid-cycle.
   always_comb begin
      gen_active_d = gen_active_q;
      period_cnt_d = period_cnt_q;
      tick_idx_d   = tick_idx_q;
      tick         = 1'b0;
      if (!bus.ENABLE) begin
         gen_active_d = 1'b0;
      end else if (bus.PULSE_50_HZ) begin
         tick         = 1'b1;
         tick_idx_d   = '0;
         period_cnt_d = '0;
         gen_active_d = (SAMPLES_PER_CYCLE > 1);
      end else if (gen_active_q) begin
         if (period_cnt_q == PCntW'(SAMPLE_PERIOD - 1)) begin
            tick         = 1'b1;
            period_cnt_d = '0;
            tick_idx_d   = tick_idx_q + IDX_WIDTH'(1);
            if (tick_idx_q == IDX_WIDTH'(SAMPLES_PER_CYCLE - 2)) begin
               gen_active_d = 1'b0;
            end
         end else begin
            period_cnt_d = period_cnt_q + PCntW'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         gen_active_q  <= 1'b0;
         period_cnt_q  <= '0;
         tick_idx_q    <= '0;
         state_q       <= StIdle;
         cnt_q         <= '0;
         lat_idx_q     <= '0;
         convst_q      <= 1'b0;
         valid_q       <= 1'b0;
         first_q       <= 1'b0;
         sample_idx_q  <= '0;
         err_overrun_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         gen_active_q  <= gen_active_d;
         period_cnt_q  <= period_cnt_d;
         tick_idx_q    <= tick_idx_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lat_idx_q     <= lat_idx_d;
         convst_q      <= convst_d;
         valid_q       <= valid_d;
         first_q       <= first_d;
         sample_idx_q  <= sample_idx_d;
         err_overrun_q <= err_overrun_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   // cnt_q times the CONVST pulse in StConv and the busy timeout in StWaitBusy.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + FsmCntW'(1);
      lat_idx_d = lat_idx_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (tick) begin
               state_d   = StConv;
               lat_idx_d = tick_idx_d;
            end
         end
         StConv: begin
            if (cnt_q == FsmCntW'(CONVST_WIDTH - 1)) begin
               state_d = StWaitBusy;
               cnt_d   = '0;
            end
         end
         StWaitBusy: begin
            if (!busy_sync) begin
               state_d = StDone;
            end else if (cnt_q == FsmCntW'(BUSY_TIMEOUT - 1)) begin
               state_d = StIdle;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are registered from the next state so CONVST is glitch-free at the pin.
   always_comb begin
      convst_d      = (state_d == StConv);
      valid_d       = (state_d == StDone);
      first_d       = valid_d && (lat_idx_d == '0);
      sample_idx_d  = valid_d ? lat_idx_d : sample_idx_q;
      overrun_evt   = tick && (state_q != StIdle);
      timeout_evt   = (state_q == StWaitBusy) && busy_sync &&
                      (cnt_q == FsmCntW'(BUSY_TIMEOUT - 1));
      err_overrun_d = overrun_evt | (err_overrun_q & ~bus.ERR_CLEAR);
      err_timeout_d = timeout_evt | (err_timeout_q & ~bus.ERR_CLEAR);
   end

   assign bus.CONVST       = convst_q;
   assign bus.SAMPLE_VALID = valid_q;
   assign bus.SAMPLE_IDX   = sample_idx_q;
   assign bus.CYCLE_FIRST  = first_q;
   assign bus.ERR_OVERRUN  = err_overrun_q;
   assign bus.ERR_TIMEOUT  = err_timeout_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: directed scenarios plus random traffic, checked every
// cycle against a timeline model of ticks, conversions and sticky errors.
module tb_adc_sample_scheduler;

   localparam int SPC = 4;
   localparam int SP  = 16;
   localparam int CW  = 2;
   localparam int BT  = 8;
   localparam int IW  = 2;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   adc_sample_scheduler_if #(.IDX_WIDTH(IW)) bus ();

   adc_sample_scheduler #(
      .SAMPLES_PER_CYCLE (SPC),
      .SAMPLE_PERIOD     (SP),
      .CONVST_WIDTH      (CW),
      .BUSY_TIMEOUT      (BT),
      .IDX_WIDTH         (IW)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // ADC model: BUSY rises with the first observed CONVST cycle and stays high for a
   // per-conversion hold count handed over by the reference model.
   int   hold_q[$];
   int   busy_cnt  = 0;
   logic conv_prev = 1'b0;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         busy_cnt     = 0;
         hold_q.delete();
         conv_prev    = 1'b0;
         bus.ADC_BUSY = 1'b0;
      end else begin
         #1;
         if (bus.CONVST && !conv_prev) begin
            if (hold_q.size() > 0) busy_cnt = hold_q.pop_front();
            else busy_cnt = 3;
         end
         conv_prev    = bus.CONVST;
         bus.ADC_BUSY = (busy_cnt > 0);
         if (busy_cnt > 0) busy_cnt--;
      end
   end

   // Reference model state, expressed as absolute cycle numbers.
   bit seq_active;
   int seq_t0;
   int conv_start, conv_valid_at, conv_end, conv_tmo_at, conv_idx;
   bit exp_ovr, exp_tmo;
   int plan_q[$];
   bit rand_hold;
   int val_cyc[$];
   int val_idx[$];
   int base;
   int exp4 [6] = '{0, 1, 0, 1, 2, 3};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      seq_active    = 1'b0;
      seq_t0        = 0;
      conv_start    = -1000;
      conv_valid_at = -1000;
      conv_end      = -1000;
      conv_tmo_at   = -1000;
      conv_idx      = 0;
      exp_ovr       = 1'b0;
      exp_tmo       = 1'b0;
   endtask

   task automatic check_outputs_zero(input string ctx);
      check({ctx, "_convst"}, bus.CONVST, 0);
      check({ctx, "_valid"}, bus.SAMPLE_VALID, 0);
      check({ctx, "_first"}, bus.CYCLE_FIRST, 0);
      check({ctx, "_idx"}, bus.SAMPLE_IDX, 0);
      check({ctx, "_overrun"}, bus.ERR_OVERRUN, 0);
      check({ctx, "_timeout"}, bus.ERR_TIMEOUT, 0);
   endtask

   // Checks the current cycle, applies its inputs to the model, advances one clock.
   task automatic step();
      bit exp_valid, tick, ovr_evt, tmo_evt;
      int d, k, tidx, h, e, x;
      @(negedge CLK);
      exp_valid = (cyc == conv_valid_at);
      check("convst", bus.CONVST, (cyc >= conv_start + 1) && (cyc <= conv_start + CW));
      check("sample_valid", bus.SAMPLE_VALID, exp_valid);
      check("cycle_first", bus.CYCLE_FIRST, exp_valid && (conv_idx == 0));
      if (exp_valid) check("sample_idx", bus.SAMPLE_IDX, conv_idx);
      check("err_overrun", bus.ERR_OVERRUN, exp_ovr);
      check("err_timeout", bus.ERR_TIMEOUT, exp_tmo);
      if (bus.SAMPLE_VALID === 1'b1) begin
         val_cyc.push_back(cyc);
         val_idx.push_back(int'(bus.SAMPLE_IDX));
      end

      tick = 1'b0;
      tidx = 0;
      if (!bus.ENABLE) begin
         seq_active = 1'b0;
      end else if (bus.PULSE_50_HZ) begin
         seq_active = 1'b1;
         seq_t0     = cyc;
         tick       = 1'b1;
      end else if (seq_active) begin
         d = cyc - seq_t0;
         if (d % SP == 0) begin
            k = d / SP;
            if (k < SPC) begin
               tick = 1'b1;
               tidx = k;
            end
            if (k >= SPC - 1) seq_active = 1'b0;
         end
      end

      tmo_evt = (cyc == conv_tmo_at);
      ovr_evt = 1'b0;
      if (tick) begin
         if (cyc <= conv_end) begin
            ovr_evt = 1'b1;
         end else begin
            if (plan_q.size() > 0) h = plan_q.pop_front();
            else if (rand_hold) h = $urandom_range(1, 12);
            else h = 3;
            hold_q.push_back(h);
            conv_start = cyc;
            conv_idx   = tidx;
            e          = cyc + CW + 1;
            x          = (cyc + h + 3 > e) ? cyc + h + 3 : e;
            if (x - e < BT) begin
               conv_valid_at = x + 1;
               conv_end      = x + 1;
               conv_tmo_at   = -1000;
            end else begin
               conv_valid_at = -1000;
               conv_tmo_at   = e + BT - 1;
               conv_end      = e + BT - 1;
            end
         end
      end
      exp_ovr = ovr_evt ? 1'b1 : (bus.ERR_CLEAR ? 1'b0 : exp_ovr);
      exp_tmo = tmo_evt ? 1'b1 : (bus.ERR_CLEAR ? 1'b0 : exp_tmo);

      @(posedge CLK);
      #1;
      cyc++;
      bus.PULSE_50_HZ = 1'b0;
      bus.ERR_CLEAR   = 1'b0;
   endtask

   initial begin
      bus.PULSE_50_HZ = 1'b0;
      bus.ENABLE      = 1'b1;
      bus.ERR_CLEAR   = 1'b0;
      rand_hold       = 1'b0;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      check_outputs_zero("reset");
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      cyc = 0;
      repeat (5) step();

      // Plain cycle: four evenly spaced samples.
      base = val_cyc.size();
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (SPC * SP + 10) step();
      check("s1_count", val_cyc.size() - base, SPC);
      if (val_cyc.size() - base == SPC) begin
         for (int i = 0; i < SPC; i++) begin
            check("s1_idx", val_idx[base + i], i);
            if (i > 0) check("s1_spacing", val_cyc[base + i] - val_cyc[base + i - 1], SP);
         end
      end

      // Stuck BUSY on the first conversion: timeout, next tick converts normally.
      base = val_cyc.size();
      plan_q.push_back(20);
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (SPC * SP + 10) step();
      check("s2_timeout_set", bus.ERR_TIMEOUT, 1);
      check("s2_count", val_cyc.size() - base, SPC - 1);
      if (val_cyc.size() - base == SPC - 1) check("s2_first_idx", val_idx[base], 1);
      bus.ERR_CLEAR = 1'b1;
      step();
      step();
      check("s2_timeout_clr", bus.ERR_TIMEOUT, 0);

      // Resync pulse while a conversion is in flight: its tick is an overrun.
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (3) step();
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (SPC * SP + 10) step();
      check("s3_overrun_set", bus.ERR_OVERRUN, 1);
      bus.ERR_CLEAR = 1'b1;
      step();
      step();
      check("s3_overrun_clr", bus.ERR_OVERRUN, 0);

      // Second pulse 24 cycles in: idx 0,1 then a full restart.
      base = val_cyc.size();
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (23) step();
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (SPC * SP + 10) step();
      check("s4_count", val_cyc.size() - base, 6);
      if (val_cyc.size() - base == 6) begin
         for (int i = 0; i < 6; i++) check("s4_idx", val_idx[base + i], exp4[i]);
      end

      // ENABLE low ignores the pulse; dropping it after idx 1 stops the sequence.
      base = val_cyc.size();
      bus.ENABLE      = 1'b0;
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (30) step();
      check("s5_disabled_count", val_cyc.size() - base, 0);
      bus.ENABLE      = 1'b1;
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (SP) step();
      bus.ENABLE = 1'b0;
      repeat (60) step();
      check("s5_count", val_cyc.size() - base, 2);
      bus.ENABLE = 1'b1;

      // Reset while CONVST is high.
      bus.PULSE_50_HZ = 1'b1;
      step();
      check("s6_convst_pre", bus.CONVST, 1);
      #1;
      RST = 1'b1;
      #1;
      check_outputs_zero("s6_reset");
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      cyc++;
      base = val_cyc.size();
      bus.PULSE_50_HZ = 1'b1;
      step();
      repeat (SPC * SP + 10) step();
      check("s6_count", val_cyc.size() - base, SPC);
      if (val_cyc.size() - base == SPC) check("s6_first_idx", val_idx[base], 0);

      // Random pulses, enable changes, clears and BUSY lengths.
      rand_hold = 1'b1;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 59) == 0) bus.PULSE_50_HZ = 1'b1;
         if ($urandom_range(0, 149) == 0) bus.ENABLE = ~bus.ENABLE;
         if ($urandom_range(0, 29) == 0) bus.ERR_CLEAR = 1'b1;
         step();
      end
      bus.ENABLE = 1'b1;
      repeat (20) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
